arb_grant_mux_fifo: RTL and testbench
=====================================

// Module: arb_grant_mux_fifo
// PURPOSE
//  Consumer stage behind the 3-requester round-robin arbiter. Takes the arbiter's one-hot grant,
//  muxes the granted requester's payload, tags it with source ID and buffers it in a small FIFO.
//  Drives the arbiter enable (back-pressure) and per-requester accept strobes.
//  Presents one valid/ready output stream to the downstream sink.
// PARAMETERS
//  DW     8  payload width per requester, bits
//  DEPTH  4  FIFO entries; power of 2, >= 2
//  AW     2  log2(DEPTH), set by instantiator
// PORTS
//  clk        in   1      clock, all logic on posedge
//  rstn       in   1      async active-low reset
//  req_vld    in   3      per-requester request valid (also routed to the arbiter)
//  req_data   in   3*DW   payloads, requester i at [i*DW +: DW]
//  grant      in   3      one-hot grant from arbiter, combinational, same cycle
//  arb_en     out  1      enable to arbiter; = FIFO not full
//  req_acc    out  3      accept strobe; requester i pops its request this cycle
//  out_vld    out  1      FIFO non-empty
//  out_data   out  DW     head payload
//  out_src    out  2      head source ID (0,1,2)
//  out_rdy    in   1      sink ready; pop when out_vld & out_rdy
//  level      out  AW+1   current occupancy, 0..DEPTH
//  err        out  1      sticky protocol error
// BEHAVIOUR
//  - Reset (async, rstn=0): FIFO empty, level=0, out_vld=0, out_data=0, out_src=0, err=0,
//    arb_en=0 during reset; arb_en=1 the first cycle after release.
//  - arb_en = (level != DEPTH), combinational from registered level. No push into full FIFO,
//    even if a pop happens the same cycle (no full-bypass).
//  - grant_ok = grant one-hot AND (grant & req_vld) == grant.
//  - push = arb_en & grant_ok. On push: write {src, req_data[src]}; req_acc = grant.
//    Otherwise req_acc = 3'b000.
//  - grant == 3'b000: idle, no push, no error.
//  - grant multi-hot, or grant bit set for a requester with req_vld=0, while arb_en=1:
//    no push, req_acc=0, err set next cycle and held until reset.
//  - pop = out_vld & out_rdy. out_data/out_src come from head entry (registered read pointer;
//    memory may be a reg array read combinationally at head).
//  - Latency: push in cycle N -> out_vld=1 in cycle N+1 if FIFO was empty. No write-through.
//  - Simultaneous push & pop (not full): level unchanged, both pointers advance.
//  - Pop while empty impossible (out_vld=0); push while full blocked by arb_en.
//  - Pointers AW bits, wrap modulo DEPTH; level tracked as a separate AW+1 counter.
//  - out_vld/out_data must hold stable while out_vld=1 & out_rdy=0.
//  - Reset mid-operation drops all buffered entries; no partial state survives.
// STRUCTURE
//  - Shared header arb_defs.vh: NUM_REQ=3, SRC_W=2, source ID encodings, grant one-hot constants.
//  - Sub-module sync_fifo (params W=DW+2, DEPTH, AW): push/pop/full/empty/level, async rstn.
//  - Top: grant check, one-hot -> source-ID encoder, payload mux, err flop, arb_en/req_acc logic.
// TESTING
//  1 Reset: rstn=0 mid-traffic -> out_vld=0, level=0, err=0, arb_en=0; after release arb_en=1.
//  2 Single push: req_vld=001, grant=001, req_data[0]=8'hA5 -> req_acc=001; next cycle
//    out_vld=1, out_data=A5, out_src=0, level=1.
//  3 Fill: out_rdy=0, 4 grants 001,010,100,001 -> level=4, arb_en=0; 5th grant -> req_acc=000,
//    level stays 4; then out_rdy=1 drains in order src 0,1,2,0.
//  4 Simultaneous: level=2, push (grant=010) and pop same cycle -> level=2, order preserved.
//  5 Error: grant=011 with req_vld=011 -> no push, err=1 next cycle, stays 1 until rstn=0;
//    grant=100 with req_vld=000 -> same.
//  6 Back-pressure stall: out_vld=1, out_rdy=0 for 5 cycles -> out_data/out_src unchanged.

Source files
------------

// File: rtl/arb_grant_mux_fifo_pkg.sv
// rtl/arb_grant_mux_fifo_pkg.sv - shared requester/source-ID definitions for the grant mux FIFO
package arb_grant_mux_fifo_pkg;

    localparam int NUM_REQ = 3;
    localparam int SRC_W   = 2;

    typedef enum logic [SRC_W-1:0] {
        SRC_0 = 2'd0,
        SRC_1 = 2'd1,
        SRC_2 = 2'd2
    } src_e;

    localparam logic [NUM_REQ-1:0] GNT_0 = 3'b001;
    localparam logic [NUM_REQ-1:0] GNT_1 = 3'b010;
    localparam logic [NUM_REQ-1:0] GNT_2 = 3'b100;

    function automatic logic grant_is_onehot(input logic [NUM_REQ-1:0] g);
        return (g != '0) && ((g & (g - NUM_REQ'(1))) == '0);
    endfunction

    // Only meaningful for a one-hot grant; anything else falls back to SRC_0.
    function automatic src_e grant_to_src(input logic [NUM_REQ-1:0] g);
        case (g)
            GNT_1:   return SRC_1;
            GNT_2:   return SRC_2;
            default: return SRC_0;
        endcase
    endfunction

endpackage

// File: rtl/arb_grant_mux_fifo_if.sv
// rtl/arb_grant_mux_fifo_if.sv - arbiter-side and sink-side signal bundle for the grant mux FIFO
interface arb_grant_mux_fifo_if #(
    parameter int DW = 8,
    parameter int AW = 2
);
    logic [2:0]      req_vld;
    logic [3*DW-1:0] req_data;
    logic [2:0]      grant;
    logic            arb_en;
    logic [2:0]      req_acc;
    logic            out_vld;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_src;
    logic            out_rdy;
    logic [AW:0]     level;
    logic            err;

    modport slave (
        input  req_vld, req_data, grant, out_rdy,
        output arb_en, req_acc, out_vld, out_data, out_src, level, err
    );

    modport master (
        output req_vld, req_data, grant, out_rdy,
        input  arb_en, req_acc, out_vld, out_data, out_src, level, err
    );
endinterface

// File: rtl/arb_grant_mux_fifo_sync_fifo.sv
// rtl/arb_grant_mux_fifo_sync_fifo.sv - small synchronous FIFO with separate occupancy counter
module arb_grant_mux_fifo_sync_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  level
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];
    assign level   = level_q;

    // Storage is cleared too so the head reads zero straight out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/arb_grant_mux_fifo.sv
// rtl/arb_grant_mux_fifo.sv - checks the arbiter grant, muxes the winning payload and buffers it with its source ID
module arb_grant_mux_fifo
    import arb_grant_mux_fifo_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    arb_grant_mux_fifo_if.slave  bus
);

    localparam int W = DW + SRC_W;

    src_e         src;
    logic [DW-1:0] payload;
    logic [W-1:0]  rdata;
    logic          grant_ok;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          started_q;
    logic          err_q;
    logic          bad_grant;
    logic          arb_en;

    always_comb begin
        src     = grant_to_src(bus.grant);
        payload = bus.req_data[0 +: DW];
        case (src)
            SRC_1:   payload = bus.req_data[DW +: DW];
            SRC_2:   payload = bus.req_data[2*DW +: DW];
            default: payload = bus.req_data[0 +: DW];
        endcase
    end

    assign grant_ok  = grant_is_onehot(bus.grant) && ((bus.grant & bus.req_vld) == bus.grant);
    // started_q keeps the arbiter disabled while reset is asserted even though level reads 0.
    assign arb_en    = started_q & ~full;
    assign push      = arb_en & grant_ok;
    assign bad_grant = arb_en && (bus.grant != '0) && !grant_ok;
    assign pop       = bus.out_vld & bus.out_rdy;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            started_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            started_q <= 1'b1;
            if (bad_grant) begin
                err_q <= 1'b1;
            end
        end
    end

    arb_grant_mux_fifo_sync_fifo #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .wdata ({src, payload}),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .level (bus.level)
    );

    assign bus.arb_en   = arb_en;
    assign bus.req_acc  = push ? bus.grant : 3'b000;
    assign bus.out_vld  = ~empty;
    assign bus.out_data = rdata[DW-1:0];
    assign bus.out_src  = rdata[W-1:DW];
    assign bus.err      = err_q;

endmodule

// File: tb/tb_arb_grant_mux_fifo.sv
// tb/tb_arb_grant_mux_fifo.sv - scoreboard bench for the grant mux FIFO
module tb_arb_grant_mux_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    arb_grant_mux_fifo_if #(.DW(DW), .AW(AW)) ifc ();

    arb_grant_mux_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (ifc.slave)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [9:0] sb_q[$];
    logic       err_model = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] pack3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return {c, b, a};
    endfunction

    task automatic step(input logic [2:0] g, input logic [2:0] v, input logic [23:0] d, input logic rdy);
        logic       ok;
        logic       en;
        logic       pop_now;
        logic [1:0] s;
        logic [9:0] head;
        @(negedge clk);
        ifc.grant    = g;
        ifc.req_vld  = v;
        ifc.req_data = d;
        ifc.out_rdy  = rdy;
        #1;
        ok = ((g == 3'b001) || (g == 3'b010) || (g == 3'b100)) && ((g & v) == g);
        s  = (g == 3'b010) ? 2'd1 : (g == 3'b100) ? 2'd2 : 2'd0;
        en = (sb_q.size() != DEPTH);
        check_eq("arb_en", 32'(ifc.arb_en), 32'(en));
        check_eq("req_acc", 32'(ifc.req_acc), 32'((en && ok) ? g : 3'b000));
        check_eq("out_vld", 32'(ifc.out_vld), 32'(sb_q.size() != 0));
        if (sb_q.size() != 0) begin
            head = sb_q[0];
            check_eq("out_data", 32'(ifc.out_data), 32'(head[7:0]));
            check_eq("out_src", 32'(ifc.out_src), 32'(head[9:8]));
        end
        pop_now = rdy && (sb_q.size() != 0);
        @(posedge clk);
        #1;
        if (pop_now) void'(sb_q.pop_front());
        if (en && ok) sb_q.push_back({s, d[s*8 +: 8]});
        if (en && (g != 3'b000) && !ok) err_model = 1'b1;
        check_eq("level", 32'(ifc.level), 32'(sb_q.size()));
        check_eq("err", 32'(ifc.err), 32'(err_model));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_eq("rst_out_vld", 32'(ifc.out_vld), 32'd0);
        check_eq("rst_level", 32'(ifc.level), 32'd0);
        check_eq("rst_err", 32'(ifc.err), 32'd0);
        check_eq("rst_arb_en", 32'(ifc.arb_en), 32'd0);
        check_eq("rst_out_data", 32'(ifc.out_data), 32'd0);
        check_eq("rst_out_src", 32'(ifc.out_src), 32'd0);
        sb_q.delete();
        err_model = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check_eq("arb_en_after_rst", 32'(ifc.arb_en), 32'd1);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(3'b000, 3'b000, 24'h0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] gtab [8];
        logic [2:0] g;
        logic [2:0] v;
        gtab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b000};
        rstn         = 1'b0;
        ifc.grant    = '0;
        ifc.req_vld  = '0;
        ifc.req_data = '0;
        ifc.out_rdy  = 1'b0;
        do_reset();

        // single push
        step(3'b001, 3'b001, pack3(8'hA5, 8'h00, 8'h00), 1'b0);
        step(3'b000, 3'b000, 24'h0, 1'b0);
        drain(2);

        // fill to full, blocked fifth grant, then in-order drain
        step(3'b001, 3'b111, pack3(8'h10, 8'h11, 8'h12), 1'b0);
        step(3'b010, 3'b111, pack3(8'h20, 8'h21, 8'h22), 1'b0);
        step(3'b100, 3'b111, pack3(8'h30, 8'h31, 8'h32), 1'b0);
        step(3'b001, 3'b111, pack3(8'h40, 8'h41, 8'h42), 1'b0);
        step(3'b010, 3'b111, pack3(8'h50, 8'h51, 8'h52), 1'b0);
        drain(5);

        // simultaneous push and pop at level 2
        step(3'b100, 3'b100, pack3(8'h00, 8'h00, 8'h61), 1'b0);
        step(3'b001, 3'b001, pack3(8'h62, 8'h00, 8'h00), 1'b0);
        step(3'b010, 3'b010, pack3(8'h00, 8'h63, 8'h00), 1'b1);
        drain(3);

        // mid-traffic reset
        step(3'b001, 3'b001, pack3(8'h71, 8'h00, 8'h00), 1'b0);
        step(3'b010, 3'b010, pack3(8'h00, 8'h72, 8'h00), 1'b0);
        do_reset();

        // protocol errors are sticky until reset
        step(3'b011, 3'b011, pack3(8'h81, 8'h82, 8'h83), 1'b0);
        step(3'b000, 3'b000, 24'h0, 1'b0);
        step(3'b001, 3'b001, pack3(8'h84, 8'h00, 8'h00), 1'b1);
        drain(2);
        do_reset();
        step(3'b100, 3'b000, pack3(8'h00, 8'h00, 8'h91), 1'b0);
        step(3'b000, 3'b000, 24'h0, 1'b0);
        do_reset();

        // head held stable under back-pressure
        step(3'b100, 3'b100, pack3(8'h00, 8'h00, 8'hC3), 1'b0);
        step(3'b001, 3'b001, pack3(8'h3C, 8'h00, 8'h00), 1'b0);
        for (int i = 0; i < 5; i++) step(3'b000, 3'b000, 24'h0, 1'b0);
        drain(3);

        // randomized traffic with mostly legal grants
        for (int i = 0; i < 300; i++) begin
            g = gtab[$urandom_range(0, 7)];
            v = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) != 0) v = v | g;
            step(g, v, 24'($urandom()), 1'($urandom_range(0, 2) != 0));
        end
        drain(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
